// File: rtl/databus_pkg.sv
// Shared definitions for the databus arbiter: default bus widths and the
// arbiter state encoding.
package databus_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int LEN_W      = 16;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: picks the first asserted request
// searching upward circularly from last_idx+1.
module rr_priority_select #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offset N wraps back to last_idx itself, so it is checked last.
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (int'(last_idx) + i) % N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/databus_arbiter.sv
// Round-robin arbiter sharing one databus master port among N_REQ requesters;
// each grant is held for one complete transfer, ending on ready & last.
module databus_arbiter #(
    parameter  int N_REQ      = 4,
    parameter  int AXI_ADDR_W = databus_pkg::AXI_ADDR_W,
    parameter  int AXI_DATA_W = databus_pkg::AXI_DATA_W,
    parameter  int LEN_W      = databus_pkg::LEN_W,
    localparam int IW         = $clog2(N_REQ),
    localparam int SW         = AXI_DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]      req_len_i,
    input  logic [N_REQ*AXI_DATA_W-1:0] req_wdata_i,
    input  logic [N_REQ*SW-1:0]         req_wstrb_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            req_last_o,
    output logic [AXI_DATA_W-1:0]       req_rdata_o,
    output logic                        m_valid_o,
    output logic [AXI_ADDR_W-1:0]       m_addr_o,
    output logic [LEN_W-1:0]            m_len_o,
    output logic [AXI_DATA_W-1:0]       m_wdata_o,
    output logic [SW-1:0]               m_wstrb_o,
    input  logic                        m_ready_i,
    input  logic                        m_last_i,
    input  logic [AXI_DATA_W-1:0]       m_rdata_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        busy_o
);

    import databus_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [N_REQ-1:0]  r_grant;
    logic [IW-1:0]     r_gidx;
    logic [IW-1:0]     r_last_gidx;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_done;

    // Zero-length requests are never eligible.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_elig
            assign w_elig[gi] = req_valid_i[gi] && (req_len_i[gi*LEN_W +: LEN_W] != '0);
        end
    endgenerate

    rr_priority_select #(.N(N_REQ)) u_select (
        .req      (w_elig),
        .last_idx (r_last_gidx),
        .gnt      (w_gnt),
        .idx      (w_idx),
        .any      (w_any)
    );

    assign w_done = (r_state == STATE_BUSY) && m_ready_i && m_last_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE: if (w_any)  w_state_next = STATE_BUSY;
            STATE_BUSY: if (w_done) w_state_next = STATE_IDLE;
            default:                w_state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= STATE_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_last_gidx <= IW'(N_REQ - 1);
        end else begin
            r_state <= w_state_next;
            if (r_state == STATE_IDLE && w_any) begin
                r_grant <= w_gnt;
                r_gidx  <= w_idx;
            end else if (w_done) begin
                r_grant     <= '0;
                r_last_gidx <= r_gidx;
            end
        end
    end

    // Request mux is combinational so the datapath adds no latency.
    always_comb begin
        m_valid_o = 1'b0;
        m_addr_o  = '0;
        m_len_o   = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        if (r_state == STATE_BUSY) begin
            m_valid_o = req_valid_i[r_gidx];
            m_addr_o  = req_addr_i[r_gidx*AXI_ADDR_W +: AXI_ADDR_W];
            m_len_o   = req_len_i[r_gidx*LEN_W +: LEN_W];
            m_wdata_o = req_wdata_i[r_gidx*AXI_DATA_W +: AXI_DATA_W];
            m_wstrb_o = req_wstrb_i[r_gidx*SW +: SW];
        end
    end

    assign req_ready_o = r_grant & {N_REQ{m_ready_i}};
    assign req_last_o  = r_grant & {N_REQ{m_last_i}};
    assign req_rdata_o = m_rdata_i;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state == STATE_BUSY);

endmodule

// File: tb/tb_databus_arbiter.sv
// Self-checking bench for databus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_databus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*LW-1:0]   req_len_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N*SW-1:0]   req_wstrb_i;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      req_last_o;
    logic [DW-1:0]     req_rdata_o;
    logic              m_valid_o;
    logic [AW-1:0]     m_addr_o;
    logic [LW-1:0]     m_len_o;
    logic [DW-1:0]     m_wdata_o;
    logic [SW-1:0]     m_wstrb_o;
    logic              m_ready_i;
    logic              m_last_i;
    logic [DW-1:0]     m_rdata_i;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    databus_arbiter #(.N_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .req_ready_o (req_ready_o),
        .req_last_o  (req_last_o),
        .req_rdata_o (req_rdata_o),
        .m_valid_o   (m_valid_o),
        .m_addr_o    (m_addr_o),
        .m_len_o     (m_len_o),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_ready_i   (m_ready_i),
        .m_last_i    (m_last_i),
        .m_rdata_i   (m_rdata_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Transaction-level model: who owns the bus, and who owned it last.
    bit mdl_busy;
    int mdl_owner;
    int mdl_prev;

    logic [N-1:0] samp_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit eligible(input int k);
        return req_valid_i[k] && (req_len_i[k*LW +: LW] != 0);
    endfunction

    task automatic set_req(input int k, input bit v, input logic [AW-1:0] a,
                           input logic [LW-1:0] l, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws);
        req_valid_i[k]          = v;
        req_addr_i[k*AW +: AW]  = a;
        req_len_i[k*LW +: LW]   = l;
        req_wdata_i[k*DW +: DW] = wd;
        req_wstrb_i[k*SW +: SW] = ws;
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic [N-1:0] el;
        eg = '0; er = '0; el = '0;
        if (mdl_busy) begin
            eg[mdl_owner] = 1'b1;
            er[mdl_owner] = m_ready_i;
            el[mdl_owner] = m_last_i;
        end
        chk("grant",   64'(grant_o),     64'(eg));
        chk("busy",    64'(busy_o),      64'(mdl_busy));
        chk("m_valid", 64'(m_valid_o),   mdl_busy ? 64'(req_valid_i[mdl_owner]) : 64'd0);
        chk("m_addr",  64'(m_addr_o),    mdl_busy ? 64'(req_addr_i[mdl_owner*AW +: AW]) : 64'd0);
        chk("m_len",   64'(m_len_o),     mdl_busy ? 64'(req_len_i[mdl_owner*LW +: LW]) : 64'd0);
        chk("m_wdata", 64'(m_wdata_o),   mdl_busy ? 64'(req_wdata_i[mdl_owner*DW +: DW]) : 64'd0);
        chk("m_wstrb", 64'(m_wstrb_o),   mdl_busy ? 64'(req_wstrb_i[mdl_owner*SW +: SW]) : 64'd0);
        chk("ready",   64'(req_ready_o), 64'(er));
        chk("last",    64'(req_last_o),  64'(el));
        chk("rdata",   64'(req_rdata_o), 64'(m_rdata_i));
    endtask

    // One clock: settle, compare, advance DUT and model on the same edge.
    task automatic cycle();
        #1;
        check_model();
        samp_ready = req_ready_o;
        @(posedge clk);
        if (rst) begin
            mdl_busy = 1'b0;
            mdl_prev = N - 1;
        end else if (!mdl_busy) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (mdl_prev + i) % N;
                if (eligible(k)) begin
                    mdl_busy  = 1'b1;
                    mdl_owner = k;
                    break;
                end
            end
        end else if (m_ready_i && m_last_i) begin
            mdl_busy = 1'b0;
            mdl_prev = mdl_owner;
        end
        #1;
    endtask

    task automatic beat(input bit r, input bit l);
        m_ready_i = r;
        m_last_i  = l;
        m_rdata_i = $urandom;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        beat(0, 0);
        beat(0, 0);
        rst = 1'b0;
    endtask

    int pulses;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req_valid_i = '0; req_addr_i = '0; req_len_i = '0;
        req_wdata_i = '0; req_wstrb_i = '0;
        m_ready_i = 1'b0; m_last_i = 1'b0; m_rdata_i = '0;
        mdl_busy = 1'b0; mdl_owner = 0; mdl_prev = N - 1;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        #1;
        chk("reset_grant", 64'(grant_o), 64'd0);
        chk("reset_busy",  64'(busy_o),  64'd0);

        // Single requester, 4 beats
        set_req(1, 1, 32'h1000_0100, 16, 32'h0, 4'h0);
        beat(0, 0);
        chk("single_grant", 64'(grant_o), 64'b0010);
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            beat(1, b == 3);
            if (samp_ready[1]) pulses++;
        end
        set_req(1, 0, 32'h0, 0, 32'h0, 4'h0);
        m_ready_i = 0; m_last_i = 0;
        chk("single_pulses", 64'(pulses), 64'd4);
        chk("single_release", 64'(busy_o), 64'd0);

        // Round-robin order with single-beat transfers
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1, 32'h2000_0000 + 32'(k * 16), 4, 32'h0, 4'h0);
        for (int t = 0; t < 5; t++) begin
            beat(0, 0);
            chk("rr_order", 64'(grant_o), 64'(1 << order[t]));
            beat(1, 1);
            chk("rr_idle_gap", 64'(busy_o), 64'd0);
        end
        for (int k = 0; k < N; k++) set_req(k, 0, 32'h0, 0, 32'h0, 4'h0);

        // Zero-length request is never granted
        do_reset();
        set_req(0, 1, 32'h3000_0000, 0, 32'h0, 4'h0);
        set_req(2, 1, 32'h3000_0200, 8, 32'h0, 4'h0);
        beat(0, 0);
        chk("zero_len_grant", 64'(grant_o), 64'b0100);
        beat(1, 0);
        beat(1, 1);
        set_req(2, 0, 32'h0, 0, 32'h0, 4'h0);
        for (int t = 0; t < 3; t++) begin
            beat(0, 0);
            chk("zero_len_never", 64'(grant_o), 64'd0);
        end
        set_req(0, 0, 32'h0, 0, 32'h0, 4'h0);

        // No preemption while req3 is mid-burst
        do_reset();
        set_req(3, 1, 32'h4000_0300, 12, 32'h0, 4'h0);
        beat(0, 0);
        beat(1, 0);
        set_req(1, 1, 32'h4000_0100, 8, 32'h0, 4'h0);
        for (int t = 0; t < 2; t++) begin
            beat(1, 0);
            chk("nopreempt_addr", 64'(m_addr_o), 64'h4000_0300);
        end
        beat(1, 1);
        set_req(3, 0, 32'h0, 0, 32'h0, 4'h0);
        m_ready_i = 0; m_last_i = 0;
        chk("nopreempt_gap", 64'(busy_o), 64'd0);
        beat(0, 0);
        chk("nopreempt_next", 64'(grant_o), 64'b0010);

        // Reset mid-transfer
        beat(1, 1);
        set_req(1, 0, 32'h0, 0, 32'h0, 4'h0);
        set_req(2, 1, 32'h5000_0200, 8, 32'h0, 4'h0);
        beat(0, 0);
        chk("rst_pre_grant", 64'(grant_o), 64'b0100);
        rst = 1'b1;
        beat(1, 0);
        rst = 1'b0;
        #1;
        chk("rst_abort_grant", 64'(grant_o), 64'd0);
        chk("rst_abort_valid", 64'(m_valid_o), 64'd0);
        set_req(0, 1, 32'h5000_0000, 4, 32'h0, 4'h0);
        beat(0, 0);
        chk("rst_fresh_grant", 64'(grant_o), 64'b0001);

        // Write path on the granted requester
        set_req(0, 1, 32'h5000_0000, 4, 32'hDEAD_BEEF, 4'hF);
        m_ready_i = 1'b1;
        #1;
        chk("wr_wdata", 64'(m_wdata_o), 64'hDEAD_BEEF);
        chk("wr_wstrb", 64'(m_wstrb_o), 64'hF);
        chk("wr_ready", 64'(req_ready_o), 64'b0001);
        beat(1, 1);
        for (int k = 0; k < N; k++) set_req(k, 0, 32'h0, 0, 32'h0, 4'h0);

        // Randomized traffic, including owner valid drops and non-owner churn
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(k, 1'($urandom_range(0, 1)), $urandom,
                            LW'($urandom_range(0, 3) * 4), $urandom, SW'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
